// File: rtl/johnson_counter_ctrl_if.sv
// Control and status bundle for the Johnson counter.
// master drives the controls and observes the state; slave is the counter itself.
interface johnson_counter_ctrl_if #(
  parameter int WIDTH = 6
);
  localparam int IDXW = $clog2(2*WIDTH);

  logic            en;
  logic            dir;
  logic            clr;
  logic            load;
  logic [IDXW-1:0] load_idx;
  logic [WIDTH-1:0] q;
  logic [IDXW-1:0] phase;
  logic            wrap;
  logic            illegal;
  logic            err;

  modport master (
    output en, dir, clr, load, load_idx,
    input  q, phase, wrap, illegal, err
  );

  modport slave (
    input  en, dir, clr, load, load_idx,
    output q, phase, wrap, illegal, err
  );
endinterface

// File: rtl/johnson_counter_ctrl.sv
// Parametrised up/down Johnson counter with clear, phase load, wrap pulse and
// illegal-state self-correction. One clk from controls to q/wrap; phase/illegal are combinational.
module johnson_counter_ctrl #(
  parameter  int WIDTH = 6,
  localparam int IDXW  = $clog2(2*WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  johnson_counter_ctrl_if.slave bus
);

  logic [WIDTH-1:0] q_reg;
  logic             wrap_reg;
  logic             err_reg;

  logic             illegal_c;
  logic [IDXW-1:0]  phase_c;
  logic             load_ok;
  logic             up_wrap;
  logic             down_wrap;
  int               ones;
  int               bounds;

  // Legal pattern for phase k: fill with ones from the LSB, then drain them from the LSB.
  function automatic logic [WIDTH-1:0] pattern(input int k);
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) begin
      p[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
    end
    return p;
  endfunction

  always_comb begin
    ones   = $countones(q_reg);
    bounds = 0;
    for (int i = 0; i < WIDTH-1; i++) begin
      if (q_reg[i] != q_reg[i+1]) bounds = bounds + 1;
    end
    illegal_c = (bounds > 1);
    if (illegal_c) begin
      phase_c = '0;
    end else if (q_reg[0] || (q_reg == '0)) begin
      phase_c = IDXW'(ones);
    end else begin
      phase_c = IDXW'(2*WIDTH - ones);
    end
  end

  assign load_ok   = (int'(bus.load_idx) < 2*WIDTH);
  assign up_wrap   = (q_reg == {1'b1, {(WIDTH-1){1'b0}}});
  assign down_wrap = (q_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else if (bus.clr) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else if (bus.load) begin
      wrap_reg <= 1'b0;
      if (load_ok) q_reg <= pattern(int'(bus.load_idx));
      else         err_reg <= 1'b1;
    end else if (illegal_c) begin
      // Upset recovery takes precedence over counting, even with en low.
      q_reg    <= '0;
      wrap_reg <= 1'b0;
      err_reg  <= 1'b1;
    end else if (bus.en) begin
      if (!bus.dir) begin
        q_reg    <= {q_reg[WIDTH-2:0], ~q_reg[WIDTH-1]};
        wrap_reg <= up_wrap;
      end else begin
        q_reg    <= {~q_reg[0], q_reg[WIDTH-1:1]};
        wrap_reg <= down_wrap;
      end
    end else begin
      wrap_reg <= 1'b0;
    end
  end

  assign bus.q       = q_reg;
  assign bus.phase   = phase_c;
  assign bus.wrap    = wrap_reg;
  assign bus.illegal = illegal_c;
  assign bus.err     = err_reg;

endmodule

// File: tb/tb_johnson_counter_ctrl.sv
// Bench for johnson_counter_ctrl: directed scenarios plus randomized traffic
// checked against a phase-arithmetic reference model.
module tb_johnson_counter_ctrl;
  localparam int W = 6;
  localparam int M = 2*W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int   m_phase;
  bit   m_err;
  bit   m_wrap;
  bit   m_illegal;

  always #5 clk = ~clk;

  johnson_counter_ctrl_if #(.WIDTH(W)) bus ();
  johnson_counter_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Expected ring contents for phase k, by arithmetic on the phase number.
  function automatic logic [W-1:0] exp_q(input int k);
    int v;
    if (k <= W) v = (1 << k) - 1;
    else        v = ((1 << W) - 1) - ((1 << (k - W)) - 1);
    return v[W-1:0];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_err = 0; m_wrap = 0; m_illegal = 0;
  endtask

  // One clk edge; the model advances from the same sampled inputs.
  task automatic step();
    @(posedge clk);
    if (bus.clr) begin
      m_phase = 0; m_err = 0; m_wrap = 0; m_illegal = 0;
    end else if (bus.load) begin
      m_wrap = 0;
      if (int'(bus.load_idx) < M) begin m_phase = int'(bus.load_idx); m_illegal = 0; end
      else m_err = 1;
    end else if (m_illegal) begin
      m_phase = 0; m_err = 1; m_wrap = 0; m_illegal = 0;
    end else if (bus.en) begin
      if (!bus.dir) begin m_wrap = (m_phase == M-1); m_phase = (m_phase + 1) % M; end
      else          begin m_wrap = (m_phase == 0);   m_phase = (m_phase + M - 1) % M; end
    end else begin
      m_wrap = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.en = 0; bus.dir = 0; bus.clr = 0; bus.load = 0; bus.load_idx = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    model_reset();
    checks++; if (bus.q !== '0)       begin errors++; $display("FAIL reset_q got=%b exp=%b", bus.q, '0); end
    checks++; if (bus.phase !== '0)   begin errors++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
    checks++; if (bus.wrap !== 1'b0)  begin errors++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
    checks++; if (bus.err !== 1'b0)   begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    bus.en = 1; bus.dir = 0;
    for (int i = 1; i <= M; i++) begin
      step();
      checks++; if (bus.q !== exp_q(i % M)) begin errors++; $display("FAIL up_q step=%0d got=%b exp=%b", i, bus.q, exp_q(i % M)); end
      checks++; if (int'(bus.phase) != i % M) begin errors++; $display("FAIL up_phase step=%0d got=%0d exp=%0d", i, bus.phase, i % M); end
      checks++; if (bus.wrap !== (i == M)) begin errors++; $display("FAIL up_wrap step=%0d got=%b exp=%b", i, bus.wrap, (i == M)); end
    end
  endtask

  task automatic test_count_down();
    bus.en = 1; bus.dir = 1;
    step();
    checks++; if (bus.q !== 6'b100000) begin errors++; $display("FAIL down1_q got=%b exp=100000", bus.q); end
    checks++; if (bus.phase !== 4'd11) begin errors++; $display("FAIL down1_phase got=%0d exp=11", bus.phase); end
    checks++; if (bus.wrap !== 1'b1)   begin errors++; $display("FAIL down1_wrap got=%b exp=1", bus.wrap); end
    step();
    checks++; if (bus.q !== 6'b110000) begin errors++; $display("FAIL down2_q got=%b exp=110000", bus.q); end
    checks++; if (bus.phase !== 4'd10) begin errors++; $display("FAIL down2_phase got=%0d exp=10", bus.phase); end
    checks++; if (bus.wrap !== 1'b0)   begin errors++; $display("FAIL down2_wrap got=%b exp=0", bus.wrap); end
    bus.en = 0;
  endtask

  task automatic test_load();
    bus.load = 1; bus.load_idx = 4'd8;
    step();
    checks++; if (bus.q !== 6'b111100) begin errors++; $display("FAIL load8_q got=%b exp=111100", bus.q); end
    checks++; if (bus.phase !== 4'd8)  begin errors++; $display("FAIL load8_phase got=%0d exp=8", bus.phase); end
    bus.load_idx = 4'd12;
    step();
    checks++; if (bus.q !== 6'b111100) begin errors++; $display("FAIL load12_q got=%b exp=111100", bus.q); end
    checks++; if (bus.err !== 1'b1)    begin errors++; $display("FAIL load12_err got=%b exp=1", bus.err); end
    bus.load = 0; bus.clr = 1;
    step();
    checks++; if (bus.q !== '0)        begin errors++; $display("FAIL clr_q got=%b exp=000000", bus.q); end
    checks++; if (bus.err !== 1'b0)    begin errors++; $display("FAIL clr_err got=%b exp=0", bus.err); end
    bus.clr = 0;
  endtask

  task automatic test_illegal();
    idle_inputs();
    @(negedge clk);
    force dut.q_reg = 6'b010101;
    #1;
    release dut.q_reg;
    #1;
    m_illegal = 1;
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b exp=1", bus.illegal); end
    checks++; if (bus.phase !== '0)     begin errors++; $display("FAIL illegal_phase got=%0d exp=0", bus.phase); end
    step();
    checks++; if (bus.q !== '0)         begin errors++; $display("FAIL fix_q got=%b exp=000000", bus.q); end
    checks++; if (bus.err !== 1'b1)     begin errors++; $display("FAIL fix_err got=%b exp=1", bus.err); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL fix_illegal got=%b exp=0", bus.illegal); end
  endtask

  task automatic test_hold_and_clr();
    bus.load = 1; bus.load_idx = 4'd5;
    step();
    bus.load = 0; bus.en = 0;
    for (int i = 0; i < 5; i++) begin
      bus.dir = ~bus.dir;
      step();
      checks++; if (bus.q !== exp_q(5)) begin errors++; $display("FAIL hold_q cyc=%0d got=%b exp=%b", i, bus.q, exp_q(5)); end
      checks++; if (bus.wrap !== 1'b0)  begin errors++; $display("FAIL hold_wrap cyc=%0d got=%b exp=0", i, bus.wrap); end
    end
    bus.clr = 1; bus.load = 1; bus.load_idx = 4'd3; bus.en = 1;
    step();
    checks++; if (bus.q !== '0)     begin errors++; $display("FAIL clr_over_load_q got=%b exp=000000", bus.q); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL clr_over_load_err got=%b exp=0", bus.err); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bus.en = 1; bus.dir = 0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.q !== 6'b001111) begin errors++; $display("FAIL pre_rst_q got=%b exp=001111", bus.q); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.q !== '0) begin errors++; $display("FAIL async_rst_q got=%b exp=000000", bus.q); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (bus.q !== 6'b000001) begin errors++; $display("FAIL post_rst_q got=%b exp=000001", bus.q); end
    idle_inputs();
  endtask

  task automatic test_random();
    bus.clr = 1;
    step();
    for (int i = 0; i < 400; i++) begin
      bus.en       = ($urandom_range(0, 9) < 7);
      bus.dir      = $urandom_range(0, 1);
      bus.load     = ($urandom_range(0, 9) == 0);
      bus.load_idx = 4'($urandom_range(0, 15));
      bus.clr      = ($urandom_range(0, 19) == 0);
      step();
      checks++; if (bus.q !== exp_q(m_phase)) begin errors++; $display("FAIL rnd_q cyc=%0d got=%b exp=%b", i, bus.q, exp_q(m_phase)); end
      checks++; if (int'(bus.phase) != m_phase) begin errors++; $display("FAIL rnd_phase cyc=%0d got=%0d exp=%0d", i, bus.phase, m_phase); end
      checks++; if (bus.wrap !== m_wrap) begin errors++; $display("FAIL rnd_wrap cyc=%0d got=%b exp=%b", i, bus.wrap, m_wrap); end
      checks++; if (bus.err !== m_err)   begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, bus.err, m_err); end
      checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL rnd_illegal cyc=%0d got=%b exp=0", i, bus.illegal); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_illegal();
    test_hold_and_clr();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
